// File: rtl/sample_frame_source_pkg.sv
// Shared definitions for the sample frame source: stream mode encodings and FSM state type.
`timescale 1ns/1ps
package sample_frame_source_pkg;

    localparam logic [1:0] MODE_SINGLE  = 2'b00;
    localparam logic [1:0] MODE_CONT    = 2'b01;
    localparam logic [1:0] MODE_COUNTED = 2'b10;
    localparam logic [1:0] MODE_RSVD    = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;

    // The reserved encoding behaves as a single-frame request.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == MODE_RSVD) ? MODE_SINGLE : m;
    endfunction

endpackage

// File: rtl/sample_frame_source_ram.sv
// Simple dual-port sample memory: one write port, one registered read port (read-first).
`timescale 1ns/1ps
module sample_ram_1r1w #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 1024,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Non-blocking update gives the old word on a same-address collision.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
        if (rd_en) rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sample_frame_source.sv
// Streams frames of stored samples over a valid/ready port in single, continuous or counted mode.
`timescale 1ns/1ps
module sample_frame_source
    import sample_frame_source_pkg::*;
#(
    parameter  int DATA_W    = 32,
    parameter  int FRAME_LEN = 1024,
    parameter  int CNT_W     = 16,
    localparam int AW        = $clog2(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  num_frames,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sync,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  frames_sent
);

    localparam int EW = DATA_W + 2;

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [CNT_W-1:0]  tgt_q, tgt_d, frd_q, frd_d, frames_q, frames_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              stop_q, stop_d, done_q, done_d;
    logic              r_vld_q, r_vld_d, r_sync_q, r_sync_d, r_last_q, r_last_d;
    logic [1:0]        f_cnt_q, f_cnt_d, occ_after;
    logic [EW-1:0]     ent_q [2];
    logic [EW-1:0]     ent_d [2];
    logic [EW-1:0]     head, r_ent;
    logic [DATA_W-1:0] rd_data;
    logic              f_empty, xfer, pop, push, rd_en, at_end, last_frame, final_rd;

    sample_ram_1r1w #(.DATA_W(DATA_W), .DEPTH(FRAME_LEN)) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (addr_q),
        .rd_data (rd_data)
    );

    // The RAM output register is the first buffer slot; a 2-deep skid FIFO catches stalled words.
    always_comb begin
        r_ent     = {r_sync_q, r_last_q, rd_data};
        f_empty   = (f_cnt_q == 2'd0);
        head      = f_empty ? r_ent : ent_q[0];
        xfer      = (!f_empty || r_vld_q) && m_ready;
        pop       = xfer && !f_empty;
        push      = r_vld_q && !(f_empty && xfer);
        occ_after = f_cnt_q + {1'b0, r_vld_q} - {1'b0, xfer};
        rd_en     = (state_q == ST_RUN) && (occ_after < 2'd2);
        f_cnt_d   = f_cnt_q + {1'b0, push} - {1'b0, pop};
        ent_d[0]  = ent_q[0];
        ent_d[1]  = ent_q[1];
        if (pop) ent_d[0] = ent_q[1];
        if (push) begin
            if (f_empty || (f_cnt_q == 2'd1 && pop)) ent_d[0] = r_ent;
            else                                     ent_d[1] = r_ent;
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        tgt_d      = tgt_q;
        frd_d      = frd_q;
        addr_d     = addr_q;
        stop_d     = stop_q;
        frames_d   = frames_q;
        done_d     = 1'b0;
        r_vld_d    = rd_en;
        r_sync_d   = r_sync_q;
        r_last_d   = r_last_q;
        at_end     = (addr_q == AW'(FRAME_LEN - 1));
        case (mode_q)
            MODE_CONT:    last_frame = 1'b0;
            MODE_COUNTED: last_frame = (frd_q == tgt_q - CNT_W'(1));
            default:      last_frame = 1'b1;
        endcase
        final_rd = rd_en && at_end && (last_frame || stop_q || stop);

        if (xfer && head[EW-2]) frames_d = frames_q + CNT_W'(1);
        if (rd_en) begin
            addr_d   = addr_q + AW'(1);
            r_sync_d = (addr_q == '0);
            r_last_d = at_end;
            if (at_end) frd_d = frd_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                stop_d = 1'b0;
                if (start) begin
                    frames_d = '0;
                    mode_d   = norm_mode(mode);
                    tgt_d    = num_frames;
                    frd_d    = '0;
                    addr_d   = '0;
                    if (norm_mode(mode) == MODE_COUNTED && num_frames == '0) done_d  = 1'b1;
                    else                                                     state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                stop_d = stop_q | stop;
                if (final_rd) begin
                    state_d = ST_DRAIN;
                    stop_d  = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (f_cnt_d == 2'd0 && !r_vld_d) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_SINGLE;
            tgt_q    <= '0;
            frd_q    <= '0;
            addr_q   <= '0;
            stop_q   <= 1'b0;
            frames_q <= '0;
            done_q   <= 1'b0;
            r_vld_q  <= 1'b0;
            r_sync_q <= 1'b0;
            r_last_q <= 1'b0;
            f_cnt_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            tgt_q    <= tgt_d;
            frd_q    <= frd_d;
            addr_q   <= addr_d;
            stop_q   <= stop_d;
            frames_q <= frames_d;
            done_q   <= done_d;
            r_vld_q  <= r_vld_d;
            r_sync_q <= r_sync_d;
            r_last_q <= r_last_d;
            f_cnt_q  <= f_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        ent_q[0] <= ent_d[0];
        ent_q[1] <= ent_d[1];
    end

    assign m_valid     = !f_empty || r_vld_q;
    assign m_data      = m_valid ? head[DATA_W-1:0] : '0;
    assign m_sync      = m_valid && head[EW-1];
    assign m_last      = m_valid && head[EW-2];
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_sample_frame_source.sv
// Randomized self-checking bench for sample_frame_source against a frame-level scoreboard.
`timescale 1ns/1ps
module tb_sample_frame_source;

    localparam int DW = 32;
    localparam int FL = 16;
    localparam int CW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst, start, stop, wr_en, m_ready;
    logic [1:0]    mode;
    logic [CW-1:0] num_frames;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          m_valid, m_sync, m_last, busy, done;
    logic [DW-1:0] m_data;
    logic [CW-1:0] frames_sent;

    sample_frame_source #(.DATA_W(DW), .FRAME_LEN(FL), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .num_frames(num_frames), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sync(m_sync),
        .m_last(m_last), .busy(busy), .done(done), .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            beat_cnt, done_cnt, extra_cnt, valid_seen, last_cyc;
    logic          rdy_rand = 1'b0;
    logic          gap_on = 1'b0;
    logic [DW-1:0] mem_m [FL];
    logic [DW+1:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
        tick();
        wr_en = 1'b0;
        mem_m[a] = d;
    endtask

    task automatic fill_random();
        for (int i = 0; i < FL; i++) wr(i, $urandom);
    endtask

    task automatic arm();
        beat_cnt = 0; done_cnt = 0; extra_cnt = 0; valid_seen = 0; last_cyc = -1;
    endtask

    // Expected beats: every frame replays addresses 0..FL-1 of the model memory.
    task automatic push_frames(input int n);
        for (int f = 0; f < n; f++)
            for (int i = 0; i < FL; i++)
                exp_q.push_back({i == 0, i == FL - 1, mem_m[i]});
    endtask

    task automatic start_run(input logic [1:0] md, input int nf);
        mode = md; num_frames = CW'(nf); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((busy || exp_q.size() != 0) && k < budget) begin
            tick();
            k++;
        end
        if (k >= budget) begin
            chk("timeout_busy", 64'(busy), 64'd0);
            chk("timeout_pending", 64'(exp_q.size()), 64'd0);
        end
        tick();
        tick();
    endtask

    task automatic finish_run(input string tag, input int frames, input int beats);
        chk({tag, "_beats"}, 64'(beat_cnt), 64'(beats));
        chk({tag, "_frames_sent"}, 64'(frames_sent), 64'(frames));
        chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        chk({tag, "_extra"}, 64'(extra_cnt), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor on the falling edge: scoreboard beats, stall stability, pacing and done pulses.
    initial begin
        logic          prev_stall;
        logic [DW+2:0] prev_vec;
        logic [DW+1:0] e;
        prev_stall = 1'b0;
        prev_vec   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) chk("hold", 64'({m_valid, m_sync, m_last, m_data}), 64'(prev_vec));
                if (m_valid) valid_seen++;
                if (done) done_cnt++;
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        extra_cnt++;
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", 64'({m_sync, m_last, m_data}), 64'(e));
                    end
                    if (gap_on && last_cyc >= 0) chk("gap", 64'(cyc - last_cyc), 64'd1);
                    last_cyc = cyc;
                    beat_cnt++;
                end
                prev_stall = m_valid && !m_ready;
                prev_vec   = {m_valid, m_sync, m_last, m_data};
            end
        end
    end

    initial begin
        int md, nf, k, fr;
        rst = 1'b1; start = 1'b0; stop = 1'b0; wr_en = 1'b0; m_ready = 1'b1;
        mode = 2'b00; num_frames = '0; wr_addr = '0; wr_data = '0;
        arm();
        repeat (3) tick();
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_sync", 64'(m_sync), 64'd0);
        chk("rst_last", 64'(m_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_frames", 64'(frames_sent), 64'd0);
        rst = 1'b0;
        tick();

        // Single frame of an index ramp with the sink always ready.
        for (int i = 0; i < FL; i++) wr(i, DW'(i));
        rdy_rand = 1'b0; gap_on = 1'b1;
        arm(); push_frames(1);
        start_run(2'b00, 0);
        chk("lat_n1_valid", 64'(m_valid), 64'd0);
        chk("lat_n1_busy", 64'(busy), 64'd1);
        tick();
        chk("lat_n2_valid", 64'(m_valid), 64'd1);
        wait_idle(200);
        finish_run("single", 1, 16);

        // Counted 3 frames under a random sink, with a start retried mid-run.
        fill_random();
        rdy_rand = 1'b1; gap_on = 1'b0;
        arm(); push_frames(3);
        start_run(2'b10, 3);
        repeat (10) tick();
        start_run(2'b00, 0);
        wait_idle(1000);
        finish_run("counted3", 3, 48);

        // Continuous mode: stop during beat 20, then stop exactly at the last read of frame 0,
        // then stop one read later.
        rdy_rand = 1'b0; gap_on = 1'b1;
        arm(); push_frames(2);
        start_run(2'b01, 0);
        repeat (21) tick();
        stop = 1'b1; tick(); stop = 1'b0;
        wait_idle(500);
        finish_run("cont_stop20", 2, 32);

        arm(); push_frames(1);
        start_run(2'b01, 0);
        repeat (15) tick();
        stop = 1'b1; tick(); stop = 1'b0;
        wait_idle(500);
        finish_run("cont_stop_lastrd", 1, 16);

        arm(); push_frames(2);
        start_run(2'b01, 0);
        repeat (16) tick();
        stop = 1'b1; tick(); stop = 1'b0;
        wait_idle(500);
        finish_run("cont_stop_nextrd", 2, 32);

        // A stop seen while idle must not cut the next run short.
        stop = 1'b1; tick(); stop = 1'b0; tick();
        rdy_rand = 1'b1; gap_on = 1'b0;
        arm(); push_frames(2);
        start_run(2'b10, 2);
        wait_idle(1000);
        finish_run("idle_stop", 2, 32);

        // Counted mode with zero frames completes at once with no output.
        arm();
        start_run(2'b10, 0);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_busy", 64'(busy), 64'd0);
        chk("zero_frames_clr", 64'(frames_sent), 64'd0);
        tick();
        chk("zero_done_once", 64'(done), 64'd0);
        repeat (10) tick();
        chk("zero_no_valid", 64'(valid_seen), 64'd0);
        chk("zero_done_cnt", 64'(done_cnt), 64'd1);

        // Overwrite address 5 in the same cycle it is read.
        fill_random();
        rdy_rand = 1'b0; gap_on = 1'b1;
        arm(); push_frames(1);
        mem_m[5] = 32'hDEAD;
        push_frames(1);
        start_run(2'b10, 2);
        repeat (5) tick();
        wr_en = 1'b1; wr_addr = AW'(5); wr_data = 32'hDEAD;
        tick();
        wr_en = 1'b0;
        wait_idle(500);
        finish_run("collision", 2, 32);

        // Reset while beat 7 is presented, then a fresh single frame.
        arm(); push_frames(2);
        start_run(2'b01, 0);
        repeat (8) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 64'(m_valid), 64'd0);
        chk("mid_rst_sync", 64'(m_sync), 64'd0);
        chk("mid_rst_last", 64'(m_last), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_frames", 64'(frames_sent), 64'd0);
        chk("mid_rst_beats", 64'(beat_cnt), 64'd7);
        rst = 1'b0;
        exp_q.delete();
        tick();
        chk("post_rst_valid", 64'(m_valid), 64'd0);
        arm(); push_frames(1);
        start_run(2'b00, 0);
        wait_idle(500);
        finish_run("after_rst", 1, 16);

        // Random runs; continuous runs stop at a random read index with the sink always ready.
        for (int it = 0; it < 6; it++) begin
            fill_random();
            md = $urandom_range(0, 3);
            arm();
            if (md == 1) begin
                rdy_rand = 1'b0; gap_on = 1'b1;
                k  = $urandom_range(0, 40);
                fr = k / FL + 1;
                push_frames(fr);
                start_run(2'b01, 0);
                repeat (k) tick();
                stop = 1'b1; tick(); stop = 1'b0;
            end else begin
                rdy_rand = 1'b1; gap_on = 1'b0;
                nf = (md == 2) ? $urandom_range(1, 3) : 1;
                fr = nf;
                push_frames(fr);
                start_run(2'(md), nf);
            end
            wait_idle(2000);
            finish_run("rand", fr, fr * FL);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
